// File: rtl/slow_tick_timer.sv
// Down-counting tick timer: rising edges of the divided clock are counted against a
// latched period, producing a one-cycle expiry pulse in one-shot or auto-reload mode.
module slow_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_div_in_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         periodic_i,
  input  logic [W-1:0] period_i,
  output logic         busy_o,
  output logic         expired_o,
  output logic [W-1:0] count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic         div_q;
  logic [W-1:0] count_q;
  logic [W-1:0] period_l_q;
  logic         periodic_l_q;
  logic         busy_q;
  logic         expired_q;

  logic tick;
  logic load_ok;
  logic last_tick;

  // The divider output is already a clk-domain register, so a single stage suffices.
  assign tick      = clk_div_in_i & ~div_q;
  assign load_ok   = start_i & (period_i != '0);
  assign last_tick = tick & (count_q == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= 1'b0;
      count_q      <= '0;
      period_l_q   <= '0;
      periodic_l_q <= 1'b0;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      div_q     <= clk_div_in_i;
      expired_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_ok) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            count_q      <= period_i;
            period_l_q   <= period_i;
            periodic_l_q <= periodic_i;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (load_ok) begin
            // Restart swallows any coincident tick so the new interval is full length.
            count_q      <= period_i;
            period_l_q   <= period_i;
            periodic_l_q <= periodic_i;
          end else if (last_tick) begin
            expired_q <= 1'b1;
            if (periodic_l_q) begin
              count_q <= period_l_q;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              count_q <= '0;
            end
          end else if (tick) begin
            count_q <= count_q - ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign expired_o = expired_q;
  assign count_o   = count_q;

endmodule
